// File: rtl/i2c_pkg.sv
// Shared widths and arbiter state encoding for the I2C master arbiter slice.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_DONE = 3'd2,
    RESPOND   = 3'd3,
    GAP       = 3'd4
  } arb_state_t;

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module i2c_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] pick,
  output logic [PW-1:0]    idx,
  output logic             any_req
);

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % N_REQ;
    return PW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest set request wins.
  always_comb begin
    any_req = |req;
    idx     = {PW{1'b0}};
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = req[wrap_idx(ptr, k)] ? wrap_idx(ptr, k) : idx;
    end
    pick = {{(N_REQ-1){1'b0}}, any_req} << idx;
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sequencing single-byte I2C transactions from N_REQ
// requesters into one master engine, with bus-free gap and watchdog timeout.
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk_400,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*I2C_ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0]            req_rw,
  input  logic [N_REQ*I2C_DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            resp_valid,
  output logic [I2C_DATA_W-1:0]       resp_rdata,
  output logic                        resp_err,
  output logic                        resp_timeout,
  output logic                        m_start,
  output logic [I2C_ADDR_W-1:0]       m_addr,
  output logic                        m_rw,
  output logic [I2C_DATA_W-1:0]       m_wdata,
  input  logic                        m_busy,
  input  logic                        m_done,
  input  logic                        m_ack_error,
  input  logic [I2C_DATA_W-1:0]       m_rdata
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_t       state_r;
  arb_state_t       state_next_s;
  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    idx_r;
  logic [PW-1:0]    ptr_next_s;
  logic [N_REQ-1:0] pick_s;
  logic [PW-1:0]    pick_idx_s;
  logic             any_req_s;
  logic [TW-1:0]    tcnt_r;
  logic [GW-1:0]    gap_cnt_r;
  logic             expire_s;
  logic             gap_last_s;

  i2c_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_r),
    .pick    (pick_s),
    .idx     (pick_idx_s),
    .any_req (any_req_s)
  );

  assign expire_s   = (tcnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign gap_last_s = (gap_cnt_r == GW'(GAP_CYCLES - 1));
  assign ptr_next_s = (idx_r == PW'(N_REQ - 1)) ? {PW{1'b0}} : idx_r + 1'b1;

  // State register.
  always_ff @(posedge clk_400) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; m_done takes priority over watchdog expiry.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) state_next_s = ISSUE;
        else           state_next_s = IDLE;
      end
      ISSUE: begin
        if (!m_busy) state_next_s = WAIT_DONE;
        else         state_next_s = ISSUE;
      end
      WAIT_DONE: begin
        if (m_done || expire_s) state_next_s = RESPOND;
        else                    state_next_s = WAIT_DONE;
      end
      RESPOND: begin
        if (GAP_CYCLES == 0) state_next_s = IDLE;
        else                 state_next_s = GAP;
      end
      GAP: begin
        if (gap_last_s) state_next_s = IDLE;
        else            state_next_s = GAP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Registered outputs, request latches, pointer and counters.
  always_ff @(posedge clk_400) begin
    if (rst) begin
      gnt          <= {N_REQ{1'b0}};
      resp_valid   <= {N_REQ{1'b0}};
      resp_rdata   <= {I2C_DATA_W{1'b0}};
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
      m_start      <= 1'b0;
      m_addr       <= {I2C_ADDR_W{1'b0}};
      m_rw         <= 1'b0;
      m_wdata      <= {I2C_DATA_W{1'b0}};
      ptr_r        <= {PW{1'b0}};
      idx_r        <= {PW{1'b0}};
      tcnt_r       <= {TW{1'b0}};
      gap_cnt_r    <= {GW{1'b0}};
    end else begin
      m_start    <= 1'b0;
      resp_valid <= {N_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            gnt     <= pick_s;
            idx_r   <= pick_idx_s;
            m_addr  <= req_addr[int'(pick_idx_s)*I2C_ADDR_W +: I2C_ADDR_W];
            m_rw    <= req_rw[pick_idx_s];
            m_wdata <= req_wdata[int'(pick_idx_s)*I2C_DATA_W +: I2C_DATA_W];
          end
        end
        ISSUE: begin
          if (!m_busy) begin
            m_start <= 1'b1;
            tcnt_r  <= {TW{1'b0}};
          end
        end
        WAIT_DONE: begin
          if (m_done) begin
            resp_valid   <= gnt;
            resp_rdata   <= m_rw ? m_rdata : {I2C_DATA_W{1'b0}};
            resp_err     <= m_ack_error;
            resp_timeout <= 1'b0;
          end else if (expire_s) begin
            resp_valid   <= gnt;
            resp_rdata   <= {I2C_DATA_W{1'b0}};
            resp_err     <= 1'b1;
            resp_timeout <= 1'b1;
          end else if (!m_start) begin
            // The watchdog starts once the start pulse has been delivered.
            tcnt_r <= tcnt_r + 1'b1;
          end
        end
        RESPOND: begin
          gnt       <= {N_REQ{1'b0}};
          ptr_r     <= ptr_next_s;
          gap_cnt_r <= {GW{1'b0}};
        end
        GAP: begin
          gap_cnt_r <= gap_cnt_r + 1'b1;
        end
        default: begin
          gnt <= {N_REQ{1'b0}};
        end
      endcase
    end
  end

endmodule
